// File: rtl/rob_port_driver.sv
// rob_port_driver: in-order result queue in front of one ROB write port.
// Completed results are buffered in a circular FIFO and presented one at a
// time on the ROB port; a pending request is held stable under port_stall.
module rob_port_driver #(
    parameter int unsigned REGISTER_SIZE    = 32,
    parameter int unsigned REG_ADDRESS_SIZE = 5,
    parameter int unsigned ID_SIZE          = 1,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [ID_SIZE-1:0]                 in_id,
    input  logic                               in_w,
    input  logic [REG_ADDRESS_SIZE-1:0]        in_address,
    input  logic [REGISTER_SIZE-1:0]           in_data,
    output logic                               in_ready,
    output logic [ID_SIZE-1:0]                 port_id,
    output logic [REG_ADDRESS_SIZE-1:0]        port_address,
    output logic [REGISTER_SIZE-1:0]           port_data,
    output logic                               port_w,
    output logic                               port_req,
    input  logic                               port_stall,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [ID_SIZE-1:0]          id_mem   [FIFO_DEPTH];
    logic                        w_mem    [FIFO_DEPTH];
    logic [REG_ADDRESS_SIZE-1:0] addr_mem [FIFO_DEPTH];
    logic [REGISTER_SIZE-1:0]    data_mem [FIFO_DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshakes and port outputs; request drops at once while reset is low.
    always_comb begin
        in_ready = reset && (count_q < CW'(FIFO_DEPTH));
        port_req = reset && (count_q != '0);
        push     = in_valid && in_ready;
        pop      = port_req && !port_stall;
        count    = count_q;
        if (port_req) begin
            port_id      = id_mem[head_q];
            port_w       = w_mem[head_q];
            port_address = addr_mem[head_q];
            port_data    = data_mem[head_q];
        end else begin
            port_id      = '0;
            port_w       = 1'b0;
            port_address = '0;
            port_data    = '0;
        end
    end

    // Next-state for pointers and occupancy; flush discards same-cycle push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; written at tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            id_mem[tail_q]   <= in_id;
            w_mem[tail_q]    <= in_w;
            addr_mem[tail_q] <= in_address;
            data_mem[tail_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_rob_port_driver.sv
// Directed self-checking bench for rob_port_driver.
module tb_rob_port_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [0:0]  in_id;
    logic        in_w;
    logic [4:0]  in_address;
    logic [31:0] in_data;
    logic        in_ready;
    logic [0:0]  port_id;
    logic [4:0]  port_address;
    logic [31:0] port_data;
    logic        port_w;
    logic        port_req;
    logic        port_stall;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    rob_port_driver dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_id        (in_id),
        .in_w         (in_w),
        .in_address   (in_address),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .port_id      (port_id),
        .port_address (port_address),
        .port_data    (port_data),
        .port_w       (port_w),
        .port_req     (port_req),
        .port_stall   (port_stall),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_id = 1'b1; in_w = 1'b1;
        in_address = 5'd7; in_data = 32'hdead_beef; port_stall = 1'b0;
        tick();
        tick();
        checks++;
        if (port_req !== 1'b0) begin
            failures++; $display("FAIL reset_req got=%b want=0", port_req);
        end
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL reset_count got=%0d want=0", count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        checks++;
        if ({port_id, port_w, port_address, port_data} !== 39'd0) begin
            failures++;
            $display("FAIL reset_payload got=%h/%b/%h/%h want=0", port_id, port_w,
                     port_address, port_data);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_id = 1'b1; in_w = 1'b1; in_address = 5'd1; in_data = 32'd1;
        port_stall = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (port_req !== 1'b1 || count !== 3'd1) begin
            failures++; $display("FAIL single_req got req=%b cnt=%0d want req=1 cnt=1", port_req, count);
        end
        checks++;
        if (port_id !== 1'b1 || port_w !== 1'b1 || port_address !== 5'd1 || port_data !== 32'd1) begin
            failures++;
            $display("FAIL single_payload got=%h/%b/%h/%h want=1/1/1/1", port_id, port_w,
                     port_address, port_data);
        end
        tick();
        checks++;
        if (count !== 3'd0 || port_req !== 1'b0 || port_data !== 32'd0) begin
            failures++;
            $display("FAIL single_pop got cnt=%0d req=%b data=%h want 0/0/0", count, port_req, port_data);
        end
    endtask

    task automatic test_stall();
        port_stall = 1'b1;
        in_valid = 1'b1; in_id = 1'b0; in_w = 1'b0; in_address = 5'd0; in_data = 32'd1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (port_req !== 1'b1 || port_id !== 1'b0 || port_w !== 1'b0 ||
                port_address !== 5'd0 || port_data !== 32'd1 || count !== 3'd1) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got req=%b data=%h cnt=%0d want 1/1/1",
                         i, port_req, port_data, count);
            end
            tick();
        end
        port_stall = 1'b0;
        #1;
        checks++;
        if (port_req !== 1'b1 || port_data !== 32'd1) begin
            failures++; $display("FAIL stall_release got req=%b data=%h want 1/1", port_req, port_data);
        end
        tick();
        checks++;
        if (count !== 3'd0 || port_req !== 1'b0) begin
            failures++; $display("FAIL stall_accept got cnt=%0d req=%b want 0/0", count, port_req);
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_seq [6];
        logic [31:0] push_seq [2];
        int          idx;
        int          pidx;
        exp_seq[0] = 32'd10; exp_seq[1] = 32'd11; exp_seq[2] = 32'd12;
        exp_seq[3] = 32'd13; exp_seq[4] = 32'd15; exp_seq[5] = 32'd16;
        push_seq[0] = 32'd15; push_seq[1] = 32'd16;
        port_stall = 1'b1;
        in_w = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_id = 1'(k); in_address = 5'(k); in_data = 32'(10 + k);
            if (k == 4) begin
                #1;
                checks++;
                if (in_ready !== 1'b0 || count !== 3'd4) begin
                    failures++;
                    $display("FAIL full_state got rdy=%b cnt=%0d want 0/4", in_ready, count);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || port_data !== 32'd10) begin
            failures++;
            $display("FAIL full_no_overflow got cnt=%0d head=%0d want 4/10", count, port_data);
        end
        port_stall = 1'b0;
        idx = 0;
        pidx = 0;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            in_valid = (pidx < 2);
            if (pidx < 2) in_data = push_seq[pidx];
            #1;
            if (port_req === 1'b1) begin
                checks++;
                if (port_data !== exp_seq[idx]) begin
                    failures++;
                    $display("FAIL wrap_order idx=%0d got=%0d want=%0d", idx, port_data, exp_seq[idx]);
                end
                idx++;
            end
            if (in_valid && in_ready) pidx++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (idx !== 6 || count !== 3'd0) begin
            failures++; $display("FAIL wrap_done got n=%0d cnt=%0d want 6/0", idx, count);
        end
    endtask

    task automatic test_back_to_back();
        port_stall = 1'b0;
        in_valid = 1'b1; in_id = 1'b0; in_w = 1'b1; in_address = 5'd3; in_data = 32'h55;
        tick();
        in_id = 1'b1; in_address = 5'd4; in_data = 32'h66;
        checks++;
        if (count !== 3'd1 || port_data !== 32'h55) begin
            failures++; $display("FAIL sim_pre got cnt=%0d data=%h want 1/55", count, port_data);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || port_data !== 32'h66 || port_address !== 5'd4 || port_id !== 1'b1) begin
            failures++;
            $display("FAIL sim_post got cnt=%0d data=%h addr=%0d want 1/66/4", count, port_data,
                     port_address);
        end
        tick();
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL sim_drain got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        port_stall = 1'b1;
        in_w = 1'b0; in_id = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_address = 5'(k); in_data = 32'(20 + k);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || port_data !== 32'd20) begin
            failures++; $display("FAIL flush_pre got cnt=%0d data=%0d want 3/20", count, port_data);
        end
        flush = 1'b1;
        in_valid = 1'b1; in_data = 32'd99;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || port_req !== 1'b0 || in_ready !== 1'b1 || port_data !== 32'd0) begin
            failures++;
            $display("FAIL flush_clear got cnt=%0d req=%b rdy=%b data=%h want 0/0/1/0", count,
                     port_req, in_ready, port_data);
        end
        port_stall = 1'b0;
        in_valid = 1'b1; in_w = 1'b1; in_address = 5'd9; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        checks++;
        if (port_req !== 1'b1 || port_data !== 32'h77 || port_address !== 5'd9) begin
            failures++;
            $display("FAIL flush_after got req=%b data=%h addr=%0d want 1/77/9", port_req,
                     port_data, port_address);
        end
        tick();
        checks++;
        if (count !== 3'd0) begin
            failures++; $display("FAIL flush_drain got cnt=%0d want 0", count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_full_wrap();
        test_back_to_back();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
